// File: rtl/pgm_pkg.sv
// Shared types and defaults for the PGM ROM download path into DDRAM.
package pgm_pkg;

  localparam logic [28:0] DDR_GFX_BASE = 29'h0300_0000;
  localparam logic [7:0]  ROM_IDX_GFX  = 8'd1;

  typedef struct packed {
    logic [28:0] addr;
    logic [63:0] data;
    logic [7:0]  be;
  } ddr_wr_t;

  typedef enum logic [1:0] {
    LDR_IDLE,
    LDR_LOAD,
    LDR_DRAIN,
    LDR_DONE
  } ldr_state_t;

endpackage

// File: rtl/pgm_ddr_wr_slot.sv
// Single-entry DDRAM write holding register: load when empty (or while the
// current entry is being accepted), present stably until !busy.
module pgm_ddr_wr_slot
  import pgm_pkg::*;
(
  input  logic    clk,
  input  logic    reset_n,
  input  logic    load,
  input  ddr_wr_t load_entry,
  input  logic    busy,
  output logic    full,
  output logic    accept,
  output ddr_wr_t entry
);

  logic    full_reg;
  ddr_wr_t entry_reg;

  assign accept = full_reg && !busy;
  assign full   = full_reg;
  assign entry  = entry_reg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      full_reg  <= 1'b0;
      entry_reg <= '0;
    end else if (load) begin
      full_reg  <= 1'b1;
      entry_reg <= load_entry;
    end else if (accept) begin
      full_reg  <= 1'b0;
    end
  end

endmodule

// File: rtl/pgm_rom_loader.sv
// Packs the 16-bit HPS ROM download into 64-bit DDRAM writes and raises
// rom_ready once the whole image has been committed.
module pgm_rom_loader
  import pgm_pkg::*;
#(
  parameter logic [7:0]  ROM_INDEX = ROM_IDX_GFX,
  parameter logic [28:0] DDR_BASE  = DDR_GFX_BASE
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        ioctl_download,
  input  logic        ioctl_wr,
  input  logic [26:0] ioctl_addr,
  input  logic [15:0] ioctl_dout,
  input  logic [7:0]  ioctl_index,
  output logic        ioctl_wait,
  input  logic        ddram_busy,
  output logic        ddram_we,
  output logic [28:0] ddram_addr,
  output logic [63:0] ddram_din,
  output logic [7:0]  ddram_be,
  output logic [3:0]  ddram_burstcnt,
  output logic        rom_ready
);

  ldr_state_t  state_reg, state_next;
  logic [23:0] acc_row_reg, acc_row_next;
  logic [63:0] acc_data_reg, acc_data_next;
  logic [7:0]  acc_be_reg, acc_be_next;
  logic        acc_valid_reg, acc_valid_next;
  logic        acc_flush_reg, acc_flush_next;
  logic        rom_ready_reg;

  logic        active, wr_en, diff_row, flush;
  logic        slot_full, slot_accept, slot_free;
  logic        drain_flush, set_ready, clr_ready;
  logic [1:0]  lane;
  logic [3:0]  lane_hit;
  logic [63:0] base_data, merged_data;
  logic [7:0]  base_be, merged_be;
  logic        unused_addr_bit;
  ddr_wr_t     slot_load_entry, slot_entry;

  assign unused_addr_bit = ioctl_addr[0];

  assign active    = ioctl_download && (ioctl_index == ROM_INDEX);
  assign wr_en     = active && ioctl_wr;
  assign lane      = ioctl_addr[2:1];
  assign diff_row  = wr_en && acc_valid_reg && (ioctl_addr[26:3] != acc_row_reg);
  assign slot_free = !slot_full || slot_accept;
  assign flush     = acc_valid_reg && slot_free && (acc_flush_reg || diff_row || drain_flush);

  // A flushing accumulator restarts empty so a concurrent word begins a fresh row.
  assign base_data = flush ? 64'd0 : acc_data_reg;
  assign base_be   = flush ? 8'd0  : acc_be_reg;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign lane_hit[gi]             = wr_en && (lane == 2'(gi));
      assign merged_data[16*gi +: 16] = lane_hit[gi] ? ioctl_dout : base_data[16*gi +: 16];
      assign merged_be[2*gi +: 2]     = lane_hit[gi] ? 2'b11 : base_be[2*gi +: 2];
    end
  endgenerate

  always_comb begin
    acc_row_next   = acc_row_reg;
    acc_data_next  = merged_data;
    acc_be_next    = merged_be;
    acc_valid_next = acc_valid_reg && !flush;
    acc_flush_next = acc_flush_reg && !flush;
    if (wr_en) begin
      acc_row_next   = ioctl_addr[26:3];
      acc_valid_next = 1'b1;
      acc_flush_next = acc_flush_next || lane_hit[3];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc_row_reg   <= '0;
      acc_data_reg  <= '0;
      acc_be_reg    <= '0;
      acc_valid_reg <= 1'b0;
      acc_flush_reg <= 1'b0;
    end else begin
      acc_row_reg   <= acc_row_next;
      acc_data_reg  <= acc_data_next;
      acc_be_reg    <= acc_be_next;
      acc_valid_reg <= acc_valid_next;
      acc_flush_reg <= acc_flush_next;
    end
  end

  assign slot_load_entry = '{addr: DDR_BASE + {5'd0, acc_row_reg},
                             data: acc_data_reg,
                             be:   acc_be_reg};

  pgm_ddr_wr_slot u_slot (
    .clk        (clk),
    .reset_n    (reset_n),
    .load       (flush),
    .load_entry (slot_load_entry),
    .busy       (ddram_busy),
    .full       (slot_full),
    .accept     (slot_accept),
    .entry      (slot_entry)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_reg <= LDR_IDLE;
    else          state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      LDR_IDLE:  if (active) state_next = LDR_LOAD;
      LDR_LOAD:  if (!ioctl_download) state_next = LDR_DRAIN;
      LDR_DRAIN: if (!acc_valid_reg && !slot_full) state_next = active ? LDR_LOAD : LDR_DONE;
      LDR_DONE:  state_next = LDR_IDLE;
      default:   state_next = LDR_IDLE;
    endcase
  end

  always_comb begin
    drain_flush = (state_reg == LDR_DRAIN);
    set_ready   = (state_reg == LDR_DONE);
    clr_ready   = (state_reg == LDR_IDLE) && active;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)       rom_ready_reg <= 1'b0;
    else if (set_ready) rom_ready_reg <= 1'b1;
    else if (clr_ready) rom_ready_reg <= 1'b0;
  end

  assign ioctl_wait     = slot_full;
  assign ddram_we       = slot_full;
  assign ddram_addr     = slot_entry.addr;
  assign ddram_din      = slot_entry.data;
  assign ddram_be       = slot_entry.be;
  assign ddram_burstcnt = 4'd1;
  assign rom_ready      = rom_ready_reg;

endmodule

// File: tb/tb_pgm_rom_loader.sv
// Directed bench for pgm_rom_loader with a write scoreboard.
module tb_pgm_rom_loader;

  localparam logic [28:0] BASE = 29'h0300_0000;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        ioctl_download = 1'b0;
  logic        ioctl_wr = 1'b0;
  logic [26:0] ioctl_addr = '0;
  logic [15:0] ioctl_dout = '0;
  logic [7:0]  ioctl_index = 8'd1;
  logic        ddram_busy = 1'b0;
  logic        ioctl_wait;
  logic        ddram_we;
  logic [28:0] ddram_addr;
  logic [63:0] ddram_din;
  logic [7:0]  ddram_be;
  logic [3:0]  ddram_burstcnt;
  logic        rom_ready;

  pgm_rom_loader dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .ioctl_download (ioctl_download),
    .ioctl_wr       (ioctl_wr),
    .ioctl_addr     (ioctl_addr),
    .ioctl_dout     (ioctl_dout),
    .ioctl_index    (ioctl_index),
    .ioctl_wait     (ioctl_wait),
    .ddram_busy     (ddram_busy),
    .ddram_we       (ddram_we),
    .ddram_addr     (ddram_addr),
    .ddram_din      (ddram_din),
    .ddram_be       (ddram_be),
    .ddram_burstcnt (ddram_burstcnt),
    .rom_ready      (rom_ready)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [28:0] addr;
    logic [63:0] data;
    logic [7:0]  be;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   fails = 0;
  int   writes_seen = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Monitor: a write is accepted at the next rising edge when we && !busy.
  exp_t        mon_e;
  logic [63:0] mon_mask;
  always @(negedge clk) begin
    if (reset_n && ddram_we && !ddram_busy) begin
      writes_seen++;
      if (exp_q.size() == 0) begin
        check("write_expected", 64'(exp_q.size()), 64'd1);
      end else begin
        mon_e = exp_q.pop_front();
        for (int i = 0; i < 8; i++) mon_mask[8*i +: 8] = {8{mon_e.be[i]}};
        $display("write #%0d addr=%0h din=%0h be=%0h", writes_seen, ddram_addr, ddram_din, ddram_be);
        check("wr_addr", 64'(ddram_addr), 64'(mon_e.addr));
        check("wr_be",   64'(ddram_be),   64'(mon_e.be));
        check("wr_data", ddram_din & mon_mask, mon_e.data & mon_mask);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [26:0] a, input logic [15:0] d);
    int n = 0;
    while (ioctl_wait && n < 100) begin
      tick();
      n++;
    end
    if (n >= 100) check("wait_timeout", 64'(ioctl_wait), 64'd0);
    ioctl_addr = a;
    ioctl_dout = d;
    ioctl_wr   = 1'b1;
    tick();
    ioctl_wr   = 1'b0;
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (!rom_ready && n < 50) begin
      tick();
      n++;
    end
    check(tag, 64'(rom_ready), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int hi;
    int w0;
    int n;

    #2;
    check("rst_we",       64'(ddram_we),       64'd0);
    check("rst_addr",     64'(ddram_addr),     64'd0);
    check("rst_din",      ddram_din,           64'd0);
    check("rst_be",       64'(ddram_be),       64'd0);
    check("rst_burstcnt", 64'(ddram_burstcnt), 64'd1);
    check("rst_wait",     64'(ioctl_wait),     64'd0);
    check("rst_ready",    64'(rom_ready),      64'd0);
    tick();
    tick();
    reset_n = 1'b1;
    tick();

    // Full row, no back-pressure
    ioctl_download = 1'b1;
    tick();
    exp_q.push_back('{BASE, 64'h4444_3333_2222_1111, 8'hFF});
    send(27'd0, 16'h1111);
    send(27'd2, 16'h2222);
    send(27'd4, 16'h3333);
    send(27'd6, 16'h4444);
    check("t1_we_edge_n", 64'(ddram_we), 64'd0);
    tick();
    check("t1_we_edge_n1", 64'(ddram_we), 64'd1);
    check("t1_wait_high", 64'(ioctl_wait), 64'd1);
    tick();
    check("t1_we_dropped", 64'(ddram_we), 64'd0);
    check("t1_wait_low", 64'(ioctl_wait), 64'd0);
    ioctl_download = 1'b0;
    wait_ready("t1_rom_ready");

    // Two rows with DDRAM back-pressure
    ioctl_download = 1'b1;
    tick();
    tick();
    check("t2_ready_cleared", 64'(rom_ready), 64'd0);
    ddram_busy = 1'b1;
    exp_q.push_back('{BASE, 64'h4444_3333_2222_1111, 8'hFF});
    exp_q.push_back('{BASE + 29'd1, 64'h8888_7777_6666_5555, 8'hFF});
    send(27'd0, 16'h1111);
    send(27'd2, 16'h2222);
    send(27'd4, 16'h3333);
    send(27'd6, 16'h4444);
    send(27'd8, 16'h5555);
    check("t2_wait_high", 64'(ioctl_wait), 64'd1);
    hi = 0;
    repeat (20) begin
      tick();
      if (ioctl_wait) hi++;
    end
    check("t2_wait_held", 64'(hi), 64'd20);
    ddram_busy = 1'b0;
    send(27'd10, 16'h6666);
    send(27'd12, 16'h7777);
    send(27'd14, 16'h8888);
    ioctl_download = 1'b0;
    wait_ready("t2_rom_ready");
    check("t2_sb_empty", 64'(exp_q.size()), 64'd0);

    // Partial row flushed at end of download
    ioctl_download = 1'b1;
    tick();
    exp_q.push_back('{BASE, 64'h0000_0000_BBBB_AAAA, 8'h0F});
    send(27'd0, 16'hAAAA);
    send(27'd2, 16'hBBBB);
    ioctl_download = 1'b0;
    wait_ready("t3_rom_ready");
    check("t3_sb_empty", 64'(exp_q.size()), 64'd0);

    // Row change forces a flush
    ioctl_download = 1'b1;
    tick();
    exp_q.push_back('{BASE, 64'h0000_1234_0000_0000, 8'h30});
    exp_q.push_back('{BASE + 29'd2, 64'h0000_0000_0000_5678, 8'h03});
    send(27'd4, 16'h1234);
    send(27'd16, 16'h5678);
    ioctl_download = 1'b0;
    wait_ready("t4_rom_ready");
    check("t4_sb_empty", 64'(exp_q.size()), 64'd0);

    // Non-matching index is ignored
    w0 = writes_seen;
    ioctl_index = 8'd0;
    ioctl_download = 1'b1;
    tick();
    send(27'd0, 16'hDEAD);
    send(27'd2, 16'hBEEF);
    send(27'd4, 16'hCAFE);
    send(27'd6, 16'hF00D);
    ioctl_download = 1'b0;
    repeat (10) tick();
    check("t5_no_writes", 64'(writes_seen), 64'(w0));
    check("t5_ready_kept", 64'(rom_ready), 64'd1);
    ioctl_index = 8'd1;

    // Reset while a write is pending
    ioctl_download = 1'b1;
    ddram_busy = 1'b1;
    tick();
    send(27'd0, 16'h0101);
    send(27'd2, 16'h0202);
    send(27'd4, 16'h0303);
    send(27'd6, 16'h0404);
    n = 0;
    while (!ddram_we && n < 20) begin
      tick();
      n++;
    end
    check("t6_we_pending", 64'(ddram_we), 64'd1);
    reset_n = 1'b0;
    #1;
    check("t6_rst_we",       64'(ddram_we),       64'd0);
    check("t6_rst_addr",     64'(ddram_addr),     64'd0);
    check("t6_rst_din",      ddram_din,           64'd0);
    check("t6_rst_be",       64'(ddram_be),       64'd0);
    check("t6_rst_wait",     64'(ioctl_wait),     64'd0);
    check("t6_rst_ready",    64'(rom_ready),      64'd0);
    check("t6_rst_burstcnt", 64'(ddram_burstcnt), 64'd1);
    ioctl_download = 1'b0;
    ddram_busy = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    tick();
    ioctl_download = 1'b1;
    tick();
    exp_q.push_back('{BASE, 64'h0D0D_0C0C_0B0B_0A0A, 8'hFF});
    send(27'd0, 16'h0A0A);
    send(27'd2, 16'h0B0B);
    send(27'd4, 16'h0C0C);
    send(27'd6, 16'h0D0D);
    ioctl_download = 1'b0;
    wait_ready("t6_after_reset_ready");

    repeat (5) tick();
    check("final_sb_empty", 64'(exp_q.size()), 64'd0);
    check("final_write_count", 64'(writes_seen), 64'd7);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
